// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache, one 32-bit word per line, single outstanding miss.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_fetch #(
  parameter int unsigned INDEX_BITS = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_read,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        busy,
  output logic        mem_read,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = 30 - INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StMiss, StDiscard} state_e;

  state_e state_q, state_d;

  logic [Lines-1:0]   valid_q;
  logic [TagBits-1:0] tag_q  [Lines];
  logic [31:0]        data_q [Lines];

  logic        inst_ready_q, inst_ready_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        busy_q, busy_d;
  logic        mem_read_q, mem_read_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic [INDEX_BITS-1:0] idx, fill_idx;
  logic [TagBits-1:0]    tag, fill_tag;
  logic                  hit, match, fill;

  assign idx      = if_addr[INDEX_BITS+1:2];
  assign tag      = if_addr[31:INDEX_BITS+2];
  assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_q[31:INDEX_BITS+2];

  assign hit   = valid_q[idx] && (tag_q[idx] == tag);
  // mem_addr_q doubles as the pending miss address; it is held until the matching response.
  assign match = mem_ready && (mem_addr_i == mem_addr_q);
  assign fill  = match && (state_q != StIdle);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    inst_ready_d = 1'b0;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    busy_d       = busy_q;
    mem_read_d   = mem_read_q;
    mem_addr_d   = mem_addr_q;
    unique case (state_q)
      StIdle: begin
        if (if_read && !flush) begin
          if (hit) begin
            inst_ready_d = 1'b1;
            inst_d       = data_q[idx];
            inst_addr_d  = if_addr;
          end else begin
            mem_read_d = 1'b1;
            mem_addr_d = {if_addr[31:2], 2'b00};
            busy_d     = 1'b1;
            state_d    = StMiss;
          end
        end
      end
      StMiss: begin
        if (match) begin
          mem_read_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = StIdle;
          if (!flush) begin
            inst_ready_d = 1'b1;
            inst_d       = mem_data_i;
            inst_addr_d  = mem_addr_q;
          end
        end else if (flush) begin
          // The controller cannot abort, so keep the request up and swallow the reply.
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (match) begin
          mem_read_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      inst_ready_q <= 1'b0;
      inst_q       <= '0;
      inst_addr_q  <= '0;
      busy_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      inst_ready_q <= inst_ready_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      busy_q       <= busy_d;
      mem_read_q   <= mem_read_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign inst_ready = inst_ready_q;
  assign inst       = inst_q;
  assign inst_addr  = inst_addr_q;
  assign busy       = busy_q;
  assign mem_read   = mem_read_q;
  assign mem_addr_o = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic        lookup;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign lookup = (state_q == StIdle) && if_read && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (lookup) begin
      if (hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed scoreboard bench for icache_fetch; expected {addr,data} pairs are queued when a
// response is due and popped whenever inst_ready is sampled high.
module tb_icache_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_read = 1'b0;
  logic [31:0] if_addr = '0;
  logic        flush = 1'b0;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        busy;
  logic        mem_read;
  logic [31:0] mem_addr_o;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [63:0] sb[$];

  always #5 clock = ~clock;

  icache_fetch #(.INDEX_BITS(7)) dut (
    .clock      (clock),
    .reset      (reset),
    .if_read    (if_read),
    .if_addr    (if_addr),
    .flush      (flush),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_addr  (inst_addr),
    .busy       (busy),
    .mem_read   (mem_read),
    .mem_addr_o (mem_addr_o),
    .mem_ready  (mem_ready),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and act as the output monitor.
  task automatic step();
    logic [63:0] e;
    @(posedge clock);
    #1;
    if (inst_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_inst_ready", 32'(inst_ready), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("inst", inst, e[31:0]);
        chk("inst_addr", inst_addr, e[63:32]);
      end
    end
  endtask

  task automatic push(input logic [31:0] a);
    sb.push_back({a, word_of(a)});
  endtask

  task automatic read(input logic [31:0] a);
    if_read = 1'b1;
    if_addr = a;
    step();
    if_read = 1'b0;
  endtask

  task automatic hit(input logic [31:0] a);
    push(a);
    read(a);
    exp_hits++;
    chk("hit_ready", 32'(inst_ready), 32'h1);
    chk("hit_no_mem_read", 32'(mem_read), 32'h0);
  endtask

  task automatic miss_start(input logic [31:0] a);
    read(a);
    exp_misses++;
    chk("miss_mem_read", 32'(mem_read), 32'h1);
    chk("miss_busy", 32'(busy), 32'h1);
    chk("miss_addr", mem_addr_o, a);
    chk("miss_no_ready", 32'(inst_ready), 32'h0);
  endtask

  task automatic respond(input logic [31:0] a, input logic [31:0] d);
    mem_ready  = 1'b1;
    mem_addr_i = a;
    mem_data_i = d;
    step();
    mem_ready  = 1'b0;
  endtask

  task automatic finish_miss(input logic [31:0] a, input int delay);
    for (int i = 0; i < delay; i++) begin
      step();
      chk("hold_mem_read", 32'(mem_read), 32'h1);
      chk("hold_mem_addr", mem_addr_o, a);
    end
    push(a);
    respond(a, word_of(a));
    chk("fill_ready", 32'(inst_ready), 32'h1);
    chk("fill_mem_read_low", 32'(mem_read), 32'h0);
    chk("fill_busy_low", 32'(busy), 32'h0);
  endtask

  task automatic miss(input logic [31:0] a, input int delay);
    miss_start(a);
    finish_miss(a, delay);
  endtask

  initial begin
    #2 reset = 1'b1;
    #2;
    chk("rst_inst_ready", 32'(inst_ready), 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_addr", inst_addr, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Cold miss, then hit; back-to-back hits.
    miss(32'h100, 3);
    hit(32'h100);
    hit(32'h100);

    // Conflict eviction; lookup of the just-filled index in the next cycle.
    miss(32'h300, 2);
    hit(32'h300);
    miss(32'h100, 1);

    // Flush during miss: request stays up, reply fills silently; extra flush in discard.
    miss_start(32'h200);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_mem_read_held", 32'(mem_read), 32'h1);
    chk("flush_busy_held", 32'(busy), 32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("discard_mem_addr", mem_addr_o, 32'h200);
    respond(32'h200, word_of(32'h200));
    chk("discard_no_ready", 32'(inst_ready), 32'h0);
    chk("discard_mem_read_low", 32'(mem_read), 32'h0);
    hit(32'h200);

    // Flush coincident with matching reply.
    miss_start(32'h208);
    flush = 1'b1;
    respond(32'h208, word_of(32'h208));
    flush = 1'b0;
    chk("flush_fill_no_ready", 32'(inst_ready), 32'h0);
    chk("flush_fill_mem_read_low", 32'(mem_read), 32'h0);
    hit(32'h208);

    // Stale reply ignored; if_read while busy ignored.
    miss_start(32'h204);
    if_read = 1'b1;
    if_addr = 32'h100;
    respond(32'h200, 32'hDEAD_BEEF);
    if_read = 1'b0;
    chk("stale_no_ready", 32'(inst_ready), 32'h0);
    chk("stale_mem_read", 32'(mem_read), 32'h1);
    chk("stale_mem_addr", mem_addr_o, 32'h204);
    finish_miss(32'h204, 1);

    // Asynchronous reset mid-miss.
    miss_start(32'h400);
    #2 reset = 1'b1;
    #1;
    chk("arst_mem_read", 32'(mem_read), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_mem_addr", mem_addr_o, 32'h0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_inst_addr", inst_addr, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;

    // Post-reset: valid bits cleared, then stats sequence.
    miss(32'h100, 1);
    miss(32'h104, 2);
    hit(32'h100);
    hit(32'h104);
    hit(32'h100);
    flush   = 1'b1;
    if_read = 1'b1;
    if_addr = 32'h300;
    step();
    flush   = 1'b0;
    if_read = 1'b0;
    chk("flushed_req_no_ready", 32'(inst_ready), 32'h0);
    chk("flushed_req_no_mem_read", 32'(mem_read), 32'h0);
    step();
    step();
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, 32'(exp_hits));
    chk("miss_count", miss_count, 32'(exp_misses));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
# icache_fetch

Direct-mapped, read-only instruction cache between the IF stage and the memory controller's instruction-fetch port. Serves PC lookups in one cycle on a hit. On a miss it issues a single 32-bit fetch to the controller, then fills the line and returns the word. A pipeline flush can cancel an outstanding miss without stalling the controller.

## Interface
Parameters:
- `INDEX_BITS`, default 7: number of lines is 2^INDEX_BITS, one 32-bit word per line.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `if_read` in 1: IF stage requests the instruction at `if_addr`.
- `if_addr` in 32: PC. Bits [1:0] are always 0 and ignored.
- `flush` in 1: branch/jump redirect; cancels the current request.
- `inst_ready` out 1: one-cycle pulse, `inst` valid.
- `inst` out 32: instruction word.
- `inst_addr` out 32: PC of `inst`.
- `busy` out 1: miss outstanding; `if_read` is ignored.
- `mem_read` out 1: fetch request to the memory controller.
- `mem_addr_o` out 32: fetch address, word-aligned.
- `mem_ready` in 1: controller fetch-done pulse.
- `mem_addr_i` in 32: address of the returned word.
- `mem_data_i` in 32: returned word, little-endian assembled.

## Operation
Address split:
- index = `if_addr[INDEX_BITS+1:2]`
- tag = `if_addr[31:INDEX_BITS+2]`

Storage:
- `valid` is one flop per line, all cleared by `reset`.
- Tag and data arrays are not reset.

States: IDLE, MISS, DISCARD.

IDLE:
- `flush` high: drop any request this cycle; no output.
- `if_read` high and hit (valid and tag match):
  - Next cycle: `inst_ready`=1, `inst`=data, `inst_addr`=`if_addr`.
  - Remain in IDLE.
- `if_read` high and miss:
  - Latch the pending address.
  - Next cycle: `mem_read`=1, `mem_addr_o`=pending address, `busy`=1.
  - Go to MISS.

MISS:
- `mem_ready` with `mem_addr_i`==pending address:
  - Write data and tag, set valid.
  - Next cycle: `inst_ready`=1, `inst`=`mem_data_i`, `inst_addr`=pending address.
  - `mem_read`=0, `busy`=0; go to IDLE.
- `mem_ready` with a non-matching address: ignored (stale duplicate response).
- `flush` high: go to DISCARD. `mem_read` stays high, because the controller cannot abort a fetch.
- `flush` and a matching `mem_ready` in the same cycle: fill the line, suppress `inst_ready`, go to IDLE.

DISCARD:
- `mem_ready` with a matching address: fill the line (still correct code), no `inst_ready`, `mem_read`=0, go to IDLE.
- Further `flush` pulses: no effect.

General rules:
- `mem_read` and `mem_addr_o` are held constant from miss detection until the matching `mem_ready`.
- `if_read` in MISS or DISCARD is ignored. The IF stage must re-present the request once `busy` falls.
- A fill writes the array at the same edge a new IDLE lookup could start. A lookup to the just-filled index in the following cycle must see the new contents.

## Timing
- All outputs are registered.
- Reset values: `inst_ready`=0, `inst`=0, `inst_addr`=0, `busy`=0, `mem_read`=0, `mem_addr_o`=0, state IDLE.
- Hit latency: request at edge T, `inst_ready` at T+1. Back-to-back hits give one word per cycle.
- Miss latency: `mem_read` rises at T+1; `inst_ready` comes one cycle after the matching `mem_ready`.
- `inst_ready` is never high for more than one cycle per request.
- Asserting `reset` mid-miss returns to IDLE immediately, clears all valid bits, and drops `mem_read`.

## Configuration
`ICACHE_STATS_EN`:
- Defined:
  - Adds outputs `hit_count` out 32 and `miss_count` out 32, both reset to 0 and wrapping at 2^32.
  - `hit_count` increments on each IDLE hit lookup.
  - `miss_count` increments on each IDLE miss detection.
  - Requests dropped by flush count as neither.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Cold miss then hit:**
  - Read 0x00000100; controller answers `mem_data_i`=0x00500093 three cycles later → `inst_ready` once, `inst`=0x00500093.
  - Read 0x100 again → `inst_ready` at T+1, `mem_read` stays 0.
- **Conflict eviction (INDEX_BITS=7):**
  - Fill 0x100, then read 0x300 (same index, different tag) → miss; fill.
  - Read 0x100 again → miss.
- **Flush during miss:**
  - Miss on 0x200, `flush` pulsed two cycles later → `mem_read` stays high, response fills the line, no `inst_ready`.
  - Next read of 0x200 hits.
- **Stale response:** in MISS for 0x204, inject `mem_ready` with `mem_addr_i`=0x200 → ignored; the later 0x204 response completes normally.
- **Async reset mid-miss:** assert `reset` while `mem_read`=1 → all outputs 0 without a clock edge; read 0x100 afterwards misses.
- **Stats (`ICACHE_STATS_EN`):** sequence of 2 misses, 3 hits and 1 flushed request → `hit_count`=3, `miss_count`=2.
